dm_responder: RTL
=================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving log2 of memory depth in 32-bit words (4096 words, 16 KiB).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port m_data_addr, input, 32: byte address from CPU M stage.
REQ-006 SHALL have port m_data_wdata, input, 32: write data, already lane-aligned by CPU.
REQ-007 SHALL have port m_data_byteen, input, 4: per-byte write enable; bit i selects bits [8i+7:8i].
REQ-008 SHALL have port m_inst_addr, input, 32: PC of the M-stage instruction, used for trace only.
REQ-009 SHALL have port m_data_rdata, output, 32: read word at m_data_addr.
REQ-010 SHALL have port trace_valid, output, 1: one-cycle pulse per committed write.
REQ-011 SHALL have port trace_pc, output, 32: registered m_inst_addr of the committed write.
REQ-012 SHALL have port trace_addr, output, 32: word-aligned byte address of the committed write.
REQ-013 SHALL have port trace_data, output, 32: full merged word after the write.
REQ-014 SHALL have port wr_count, output, 32: number of committed writes since reset.
REQ-015 SHALL have port err, output, 1: sticky out-of-range access flag.

Function
REQ-016 SHALL decode index = (m_data_addr - BASE) >> 2 and be in range iff 0 <= m_data_addr - BASE < 4 << ADDR_W; address bits [1:0] SHALL be ignored for indexing.
REQ-017 SHALL drive m_data_rdata combinationally as mem[index] when in range and 32'h0 when out of range; read latency 0 cycles.
REQ-018 SHALL commit a write on the rising edge when m_data_byteen != 4'b0000 and the address is in range; only the enabled bytes change, and all other bytes hold.
REQ-019 SHALL accept any byteen pattern, including non-contiguous ones such as 4'b0101, applied bitwise.
REQ-020 SHALL make m_data_rdata in the write cycle return the pre-write word; the new value is visible from the next cycle.
REQ-021 SHALL, on a commit, in the next cycle assert trace_valid=1, trace_pc=previous m_inst_addr, trace_addr=BASE+(index<<2), and trace_data=merged word; trace_valid SHALL be 0 in cycles following no commit, and the other trace outputs SHALL hold their last values.
REQ-022 SHALL increment wr_count by 1 per commit, wrapping from 32'hFFFF_FFFF to 0.
REQ-023 SHALL ignore an out-of-range write (no memory change, no trace, no count) and set err=1 at the next edge.
REQ-024 SHALL set err=1 at the next edge on any out-of-range address while byteen != 0.
REQ-025 SHALL NOT set err on an out-of-range address while byteen == 0, because the CPU drives addresses every cycle.
REQ-026 SHALL keep err set until reset.
REQ-027 SHALL, on back-to-back writes to the same word in consecutive cycles, merge the second write onto the result of the first.

Reset
REQ-028 SHALL, while reset=0, immediately and independent of clk clear all memory words, trace_valid, trace_pc, trace_addr, trace_data, wr_count, and err to 0.
REQ-029 SHALL drop a write whose edge coincides with asserted reset; assertion of reset mid-sequence SHALL discard any pending trace pulse.
REQ-030 SHALL resume normal operation on the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover full-word write: addr 0x10, wdata 0x12345678, byteen 4'b1111, pc 0x3000 -> next cycle rdata@0x10=0x12345678, trace_valid=1, trace_pc=0x3000, trace_addr=0x10, wr_count=1.
REQ-032 SHALL cover byte merge: after REQ-031, addr 0x13, wdata 0xAB000000, byteen 4'b1000 -> rdata@0x10=0xAB345678, trace_data=0xAB345678, wr_count=2.
REQ-033 SHALL cover halfword plus same-cycle read: addr 0x10, wdata 0x0000BEEF, byteen 4'b0011 -> rdata in the write cycle=0xAB345678, next cycle 0xAB34BEEF.
REQ-034 SHALL cover out of range: addr 0x4000 with byteen 0 -> rdata=0 and err=0; addr 0x4000 with byteen 4'b1111 -> err=1 next edge, wr_count unchanged, no trace_valid.
REQ-035 SHALL cover asynchronous reset mid-run: drop reset low between edges -> all outputs and rdata@0x10 read 0 immediately, with no clock edge required; err=0.
REQ-036 SHALL cover counter wrap: force wr_count=32'hFFFF_FFFF, then do one write -> wr_count=0, trace_valid=1.

Source files
------------

// File: rtl/dm_responder.sv
// Single-port data memory responder for a CPU M stage: zero-latency reads, byte-enabled writes,
// and a registered write trace with a commit counter and a sticky out-of-range error flag.
module dm_responder #(
   parameter int          ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        trace_valid,
   output logic [31:0] trace_pc,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic [31:0] wr_count,
   output logic        err
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [31:0]       offset;
   logic              in_range;
   logic [ADDR_W-1:0] index;
   logic [31:0]       cur_word;
   logic [31:0]       merged;
   logic              commit;
   logic              write_req;

   // A negative offset wraps to a huge unsigned value, so one upper-bits test covers both ends.
   assign offset    = m_data_addr - BASE;
   assign in_range  = (offset >> (ADDR_W + 2)) == 32'd0;
   assign index     = offset[ADDR_W+1:2];
   assign cur_word  = mem[index];
   assign write_req = m_data_byteen != 4'b0000;
   assign commit    = write_req && in_range;

   assign m_data_rdata = in_range ? cur_word : 32'h0;

   always_comb begin
      merged = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (m_data_byteen[b]) begin
            merged[8*b +: 8] = m_data_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (commit) begin
         mem[index] <= merged;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trace_valid <= 1'b0;
         trace_pc    <= 32'h0;
         trace_addr  <= 32'h0;
         trace_data  <= 32'h0;
         wr_count    <= 32'h0;
         err         <= 1'b0;
      end else begin
         trace_valid <= commit;
         if (commit) begin
            trace_pc   <= m_inst_addr;
            trace_addr <= BASE + {{(30 - ADDR_W){1'b0}}, index, 2'b00};
            trace_data <= merged;
            wr_count   <= wr_count + 32'd1;
         end
         // Addresses are driven every cycle, so only an attempted write counts as a bad access.
         if (write_req && !in_range) begin
            err <= 1'b1;
         end
      end
   end
endmodule
